// File: rtl/led_indicator_pkg.sv
// Shared definitions for the LED indicator: FSM encodings, default parameters
// and the width helper used to size counters.
package led_indicator_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } led_state_t;

  localparam int DEF_N_LED    = 1;
  localparam int DEF_TICK_DIV = 25000;
  localparam int DEF_N_FLASH  = 3;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler 0..TICK_DIV-1; o_tick is high for the cycle in which
// the count sits at its last value.
module led_tick_gen
  import led_indicator_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  output logic                        o_tick,
  output logic [clog2(TICK_DIV)-1:0]  o_count
);

  localparam int CW = clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset)               r_count <= '0;
    else if (r_count == LAST)  r_count <= '0;
    else                       r_count <= r_count + 1'b1;
  end

  assign o_tick  = (r_count == LAST);
  assign o_count = r_count;

endmodule

// File: rtl/led_indicator.sv
// Multi-channel LED indicator: each toggle of i_state[k] flashes o_led[k]
// N_FLASH times on the shared tick. Optional IDLE dimming: LED_INDICATOR_DIM_EN.
module led_indicator
  import led_indicator_pkg::*;
#(
  parameter int N_LED    = DEF_N_LED,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int N_FLASH  = DEF_N_FLASH
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [N_LED-1:0] i_state,
  output logic [N_LED-1:0] o_led,
  output logic [N_LED-1:0] o_busy
);

  localparam int PW = clog2(2 * N_FLASH + 1);
  localparam int CW = clog2(TICK_DIV);
  localparam logic [PW-1:0] PH_LOAD = PW'(2 * N_FLASH);
  localparam logic [PW-1:0] PH_LAST = PW'(1);

  logic             w_tick;
  logic [CW-1:0]    w_count;
  logic             w_dim_on;
  logic [N_LED-1:0] r_prev;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (w_tick),
    .o_count (w_count)
  );

`ifdef LED_INDICATOR_DIM_EN
  // Lit IDLE output only in one of every four prescaler phases.
  assign w_dim_on = (w_count[1:0] == 2'd0);
`else
  logic w_unused_count;
  assign w_unused_count = ^w_count;
  assign w_dim_on       = 1'b1;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) r_prev <= '0;
    else         r_prev <= i_state;
  end

  for (genvar k = 0; k < N_LED; k++) begin : g_ch
    led_state_t    r_state;
    logic [PW-1:0] r_phase;
    logic          r_led;
    logic          r_busy;
    logic          w_change;
    logic          w_idle_led;

    assign w_change   = i_state[k] ^ r_prev[k];
    assign w_idle_led = i_state[k] & w_dim_on;

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        r_state <= ST_IDLE;
        r_phase <= '0;
        r_led   <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_change) begin
        // A change always (re)starts the flash, even on a tick edge.
        r_state <= ST_FLASH;
        r_phase <= PH_LOAD;
        r_led   <= 1'b1;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_FLASH: begin
            if (w_tick) begin
              if (r_phase == PH_LAST) begin
                r_state <= ST_IDLE;
                r_phase <= '0;
                r_led   <= w_idle_led;
                r_busy  <= 1'b0;
              end else begin
                r_phase <= r_phase - 1'b1;
                r_led   <= ~r_led;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_led   <= w_idle_led;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end

    assign o_led[k]  = r_led;
    assign o_busy[k] = r_busy;
  end

endmodule

// File: tb/tb_led_indicator.sv
// Self-checking bench for led_indicator (N_LED=2, TICK_DIV=4, N_FLASH=2).
// Honours LED_INDICATOR_DIM_EN when the build defines it.
module tb_led_indicator;

  localparam int N_LED    = 2;
  localparam int TICK_DIV = 4;
  localparam int N_FLASH  = 2;

  logic             clk;
  logic             i_reset;
  logic [N_LED-1:0] i_state;
  logic [N_LED-1:0] o_led;
  logic [N_LED-1:0] o_busy;

  led_indicator #(.N_LED(N_LED), .TICK_DIV(TICK_DIV), .N_FLASH(N_FLASH)) dut (
    .i_clock (clk),
    .i_reset (i_reset),
    .i_state (i_state),
    .o_led   (o_led),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: prescaler as an integer, per-channel remaining tick count.
  int         pre = 0;
  int         rem [N_LED];
  bit [1:0]   mled  = '0;
  bit [1:0]   mprev = '0;
  bit [1:0]   st    = '0;

  function automatic bit dim_ok(input int p);
`ifdef LED_INDICATOR_DIM_EN
    return (p % 4) == 0;
`else
    return (p >= 0);
`endif
  endfunction

  task automatic model_edge(input bit r, input bit [1:0] s);
    bit tick;
    tick = (pre == TICK_DIV - 1);
    if (r) begin
      pre = 0; mprev = '0; mled = '0;
      for (int k = 0; k < N_LED; k++) rem[k] = 0;
    end else begin
      for (int k = 0; k < N_LED; k++) begin
        if (s[k] != mprev[k]) begin
          rem[k] = 2 * N_FLASH; mled[k] = 1'b1;
        end else if (rem[k] > 0) begin
          if (tick) begin
            rem[k]--;
            mled[k] = (rem[k] == 0) ? (s[k] & dim_ok(pre)) : ~mled[k];
          end
        end else begin
          mled[k] = s[k] & dim_ok(pre);
        end
      end
      pre = (pre + 1) % TICK_DIV;
      mprev = s;
    end
  endtask

  function automatic bit [1:0] mbusy();
    bit [1:0] b;
    for (int k = 0; k < N_LED; k++) b[k] = (rem[k] > 0);
    return b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare at negedge.
  task automatic cyc(input bit r, input bit [1:0] s);
    i_reset = r;
    i_state = s;
    @(posedge clk);
    model_edge(r, s);
    @(negedge clk);
    check("model_led", o_led, mled);
    check("model_busy", o_busy, mbusy());
  endtask

  task automatic run_idle(input string nm);
    for (int i = 0; i < 100 && o_busy != 2'b00; i++) cyc(1'b0, st);
    check(nm, o_busy, 2'b00);
  endtask

  typedef struct {
    bit       rst;
    bit [1:0] st;
    bit [1:0] led;
    bit [1:0] busy;
  } vec_t;

  vec_t vec [18];
  int   cnt, p, d, hi;

  initial begin
    for (int k = 0; k < N_LED; k++) rem[k] = 0;
    // First flash after reset: prescaler starts at 0, so ticks land on edges 4,8,12,16.
    for (int i = 0; i < 3; i++)  vec[i] = '{1'b0, 2'b01, 2'b01, 2'b01};
    for (int i = 3; i < 7; i++)  vec[i] = '{1'b0, 2'b01, 2'b00, 2'b01};
    for (int i = 7; i < 11; i++) vec[i] = '{1'b0, 2'b01, 2'b01, 2'b01};
    for (int i = 11; i < 15; i++) vec[i] = '{1'b0, 2'b01, 2'b00, 2'b01};
    for (int i = 15; i < 18; i++) vec[i] = '{1'b0, 2'b01, 2'b01, 2'b00};

    i_reset = 1'b1;
    i_state = '0;

    // Reset held 20 cycles with i_state low.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 2'b00);
      check("rst_led", o_led, 2'b00);
      check("rst_busy", o_busy, 2'b00);
    end

    // Raise channel 0 and follow the full four-tick flash.
    st = 2'b01;
`ifdef LED_INDICATOR_DIM_EN
    for (int i = 0; i < 18; i++) cyc(1'b0, st);
`else
    foreach (vec[i]) begin
      i_reset = vec[i].rst;
      i_state = vec[i].st;
      @(posedge clk);
      model_edge(vec[i].rst, vec[i].st);
      @(negedge clk);
      check("tbl_led", o_led, vec[i].led);
      check("tbl_busy", o_busy, vec[i].busy);
    end
`endif

    // Restart: flash on a rise, drop the input one tick in, measure the new run.
    st = 2'b00; cyc(1'b0, st); run_idle("idle_before_restart");
    st = 2'b01; cyc(1'b0, st);
    for (int i = 0; i < 10 && rem[0] == 2 * N_FLASH; i++) cyc(1'b0, st);
    check("one_tick_in", o_busy, 2'b01);
    p = pre;
    d = (TICK_DIV - 1 - p + TICK_DIV) % TICK_DIV;
    if (d == 0) d = TICK_DIV;
    st = 2'b00;
    cnt = 0;
    cyc(1'b0, st);
    while (o_busy[0] && cnt < 100) begin cnt++; cyc(1'b0, st); end
    check("restart_busy_cycles", cnt, d + (2 * N_FLASH - 1) * TICK_DIV);
    check("restart_final_led", o_led, 2'b00);

    // Reset in the middle of a flash on both channels.
    st = 2'b11;
    for (int i = 0; i < 5; i++) cyc(1'b0, st);
    check("flash_before_rst", o_busy, 2'b11);
    cyc(1'b1, st);
    check("midrst_led", o_led, 2'b00);
    check("midrst_busy", o_busy, 2'b00);
    check("midrst_prescaler", dut.u_tick.o_count, 0);
    // Input high on the first cycle out of reset counts as a change.
    cyc(1'b0, st);
    check("post_rst_flash_busy", o_busy, 2'b11);
    check("post_rst_flash_led", o_led, 2'b11);
    run_idle("idle_after_rst_flash");

    // Both channels change on a tick edge: change beats the tick.
    for (int i = 0; i < 8 && pre != TICK_DIV - 1; i++) cyc(1'b0, st);
    check("at_tick_edge", pre, TICK_DIV - 1);
    st = 2'b00;
    cyc(1'b0, st);
    check("tick_change_led", o_led, 2'b11);
    check("tick_change_busy", o_busy, 2'b11);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, st);
      check("align_led", o_led[1], o_led[0]);
      check("align_busy", o_busy[1], o_busy[0]);
    end

    // Randomized activity against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N_LED; k++)
        if ($urandom_range(0, 29) == 0) st[k] = ~st[k];
      cyc($urandom_range(0, 199) == 0, st);
    end

    // Stable lit IDLE output: steady, or 1-in-4 when dimmed.
    cyc(1'b1, st);
    st = 2'b01;
    cyc(1'b0, st);
    run_idle("idle_before_dim");
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, st);
      if (o_led[0]) hi++;
    end
`ifdef LED_INDICATOR_DIM_EN
    check("dim_duty", hi, 10);
`else
    check("steady_lit", hi, 40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
